regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single register-file write port between two writeback producers: A is the ALU/immediate path, B is the load/CSR return path. It registers the granted write and drives `write_add`/`write_data`/`write_enable` of `register_file`. It also keeps a 32-entry busy scoreboard, so the decode stage can detect read-after-write hazards on rs1/rs2 while a destination write is still outstanding.

## Interface
- `WORD_LENGTH`, 32, data width; it must equal the `register_file` parameter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low.
- `a_valid`  in  1  producer A has a write pending.
- `a_ready`  out  1  producer A's write is accepted this cycle.
- `a_rd`  in  5  producer A destination register.
- `a_data`  in  WORD_LENGTH  producer A write data.
- `b_valid`  in  1  producer B has a write pending.
- `b_ready`  out  1  producer B's write is accepted this cycle.
- `b_rd`  in  5  producer B destination register.
- `b_data`  in  WORD_LENGTH  producer B write data.
- `rsv_valid`  in  1  decode is issuing an instruction that will write `rsv_rd`.
- `rsv_rd`  in  5  destination register being reserved.
- `chk_rs1`  in  5  source register to check.
- `chk_rs2`  in  5  source register to check.
- `busy_rs1`  out  1  `chk_rs1` has an outstanding write.
- `busy_rs2`  out  1  `chk_rs2` has an outstanding write.
- `rf_write_add`  out  5  to `register_file.write_add`.
- `rf_write_data`  out  WORD_LENGTH  to `register_file.write_data`.
- `rf_write_enable`  out  1  to `register_file.write_enable`.

## Operation
- Transfer rule: a producer's transfer occurs on a rising edge with `x_valid && x_ready`.
  - At most one transfer per cycle.
  - The register file never back-pressures.
- Ready generation is combinational from the valids and the priority state `prio` (values A or B):
  - `a_ready = rst && a_valid && (!b_valid || prio==A)`.
  - `b_ready = rst && b_valid && (!a_valid || prio==B)`.
  - Ready is never high without the matching valid.
- Priority update:
  - `prio` changes only on a transfer. It becomes the non-granted producer.
  - With no transfer, `prio` holds.
- Output stage:
  - On a transfer, the output stage loads `rd`/`data` from the granted producer.
  - `rf_write_enable` = 1 for exactly one cycle, and only when `rd != 0`.
  - A transfer to x0 is accepted and discarded: enable 0, scoreboard untouched.
  - With no transfer, `rf_write_enable` = 0. `rf_write_add`/`rf_write_data` hold their last values.
- Scoreboard `busy[31:0]`:
  - Set: on an edge with `rsv_valid && rsv_rd != 0`, set `busy[rsv_rd]`.
  - Clear: on an edge with `rf_write_enable`, clear `busy[rf_write_add]`.
  - Same register set and cleared on the same edge: set wins, because the newer producer owns it.
  - `busy[0]` is constant 0.
- `busy_rs1` = `busy[chk_rs1]` and `busy_rs2` = `busy[chk_rs2]`, both combinational.
  - No bypass: a write being driven to the register file in the current cycle still reads busy until the edge.

## Timing
- A transfer at edge N gives `rf_write_*` valid during cycle N..N+1.
  - The register file commits and the busy bit clears at edge N+1.
  - Decode sees `busy_rs*` = 0 from edge N+1 onward.
- Throughput: one write per cycle sustained. With both producers continuously valid, grants strictly alternate.
- Reset (`rst` = 0 at an edge):
  - Outputs after reset: `rf_write_enable` = 0, `rf_write_add` = 0, `rf_write_data` = 0, `busy` = 0, `prio` = A.
  - Ready outputs: `a_ready` and `b_ready` are 0 while `rst` = 0.
- Reset mid-operation: a pending output-stage write is dropped (enable forced 0 at the reset edge) and all reservations are cleared.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN`
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, A always wins. `prio` is tied to A and never updates, so `b_ready = rst && b_valid && !a_valid`.
  - The scoreboard and output stage are identical in both builds.

## Test plan
- Reset, then A alone:
  - Stimulus: `a_valid`=1, `a_rd`=5, `a_data`=0xDEADBEEF for one cycle.
  - Response: `a_ready`=1; next cycle `rf_write_enable`=1, `rf_write_add`=5, `rf_write_data`=0xDEADBEEF; the cycle after, `rf_write_enable`=0.
- Contention, both valid for 4 cycles (A rd=1..4, B rd=9..12):
  - Round-robin build: grant order A1, B9, A2, B10.
  - Fixed build: A1..A4, with `b_ready`=0 throughout.
- Scoreboard:
  - Stimulus: reserve rd=7, then `chk_rs1`=7; B writes rd=7 two cycles later.
  - Response: `busy_rs1`=1 from the reserve edge until the edge after `rf_write_enable` for rd=7, then 0.
- Set/clear collision:
  - Stimulus: reserve rd=3 on the same edge that `rf_write_enable` writes rd=3.
  - Response: `busy[3]` remains 1.
- x0:
  - Stimulus: A writes rd=0 with data 0x1234; reserve rd=0.
  - Response: `a_ready`=1; `rf_write_enable` stays 0; `busy_rs1` for `chk_rs1`=0 stays 0.
- Reset mid-operation:
  - Stimulus: reserve rd=8 and rd=9, transfer A rd=8, assert `rst`=0 on the next edge.
  - Response: `rf_write_enable`=0, all busy bits 0, `prio`=A. After release, with both valid, A is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, plus the RAW busy scoreboard.
// Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: A always wins).
module regfile_wb_arbiter #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [4:0]             a_rd,
    input  logic [WORD_LENGTH-1:0] a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [4:0]             b_rd,
    input  logic [WORD_LENGTH-1:0] b_data,
    input  logic                   rsv_valid,
    input  logic [4:0]             rsv_rd,
    input  logic [4:0]             chk_rs1,
    input  logic [4:0]             chk_rs2,
    output logic                   busy_rs1,
    output logic                   busy_rs2,
    output logic [4:0]             rf_write_add,
    output logic [WORD_LENGTH-1:0] rf_write_data,
    output logic                   rf_write_enable
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e                   prio_q;
    logic                    wr_en_q, wr_en_d;
    logic [4:0]              wr_add_q, wr_add_d;
    logic [WORD_LENGTH-1:0]  wr_data_q, wr_data_d;
    logic [31:0]             busy_q, busy_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
    prio_e prio_d;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of block ordering.
        if (!rst) prio_q <= PRIO_A;
        else      prio_q <= prio_d;
    end

    // The loser of this cycle's transfer gets priority next time.
    always_comb begin
        prio_d = prio_q;
        if (a_ready)      prio_d = PRIO_B;
        else if (b_ready) prio_d = PRIO_A;
    end
`else
    assign prio_q = PRIO_A;
`endif

    always_comb begin
        a_ready = rst && a_valid && (!b_valid || prio_q == PRIO_A);
        b_ready = rst && b_valid && (!a_valid || prio_q == PRIO_B);
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the if-chain leaves it unassigned and infers a latch.
        wr_en_d   = 1'b0;
        wr_add_d  = wr_add_q;
        wr_data_d = wr_data_q;
        if (a_ready) begin
            wr_add_d  = a_rd;
            wr_data_d = a_data;
            wr_en_d   = (a_rd != 5'd0);
        end else if (b_ready) begin
            wr_add_d  = b_rd;
            wr_data_d = b_data;
            wr_en_d   = (b_rd != 5'd0);
        end
    end

    // Clear first, then set: a same-edge reservation belongs to a newer producer.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q)                     busy_d[wr_add_q] = 1'b0;
        if (rsv_valid && rsv_rd != 5'd0) busy_d[rsv_rd]   = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is reset as a whole: stale reservations after a
        // flush would stall decode forever, so this storage cannot be left unreset.
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_add_q  <= 5'd0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_add_q  <= wr_add_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign busy_rs1        = busy_q[chk_rs1];
    assign busy_rs2        = busy_q[chk_rs2];
    assign rf_write_add    = wr_add_q;
    assign rf_write_data   = wr_data_q;
    assign rf_write_enable = wr_en_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with a write scoreboard and busy model.
// Follows the WB_ARB_ROUND_ROBIN_EN build option of the design.
module tb_regfile_wb_arbiter;

    localparam int WL = 32;

    typedef struct packed {
        logic          en;
        logic [4:0]    rd;
        logic [WL-1:0] data;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [4:0]    a_rd, b_rd, rsv_rd, chk_rs1, chk_rs2;
    logic [WL-1:0] a_data, b_data;
    logic          rsv_valid, busy_rs1, busy_rs2;
    logic [4:0]    rf_write_add;
    logic [WL-1:0] rf_write_data;
    logic          rf_write_enable;

    regfile_wb_arbiter #(.WORD_LENGTH(WL)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .rf_write_add(rf_write_add), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    wb_t         sb[$];
    logic [31:0] m_busy = '0;
    logic        m_prio = 1'b0;  // 0 = A, 1 = B
    logic        m_en = 1'b0;
    logic [4:0]  m_add = '0;
    logic [WL-1:0] m_data = '0;
    logic        g_a, g_b;
    logic [4:0]  grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: readies and busy checked mid-cycle, write port checked just after the edge.
    task automatic step();
        logic ea, eb;
        wb_t  w;
        @(negedge clk);
        ea = rst && a_valid && (!b_valid || m_prio == 1'b0);
        eb = rst && b_valid && (!a_valid || m_prio == 1'b1);
        check("a_ready", {31'd0, a_ready}, {31'd0, ea});
        check("b_ready", {31'd0, b_ready}, {31'd0, eb});
        check("busy_rs1", {31'd0, busy_rs1}, {31'd0, m_busy[chk_rs1]});
        check("busy_rs2", {31'd0, busy_rs2}, {31'd0, m_busy[chk_rs2]});
        g_a = ea;
        g_b = eb && !ea;
        if (!rst) begin
            m_busy = '0;
            m_prio = 1'b0;
            sb.delete();
            m_add  = '0;
            m_data = '0;
        end else begin
            if (m_en) m_busy[m_add] = 1'b0;
            if (rsv_valid && rsv_rd != 5'd0) m_busy[rsv_rd] = 1'b1;
            if (g_a)      sb.push_back('{en: a_rd != 5'd0, rd: a_rd, data: a_data});
            else if (g_b) sb.push_back('{en: b_rd != 5'd0, rd: b_rd, data: b_data});
`ifdef WB_ARB_ROUND_ROBIN_EN
            if (g_a)      m_prio = 1'b1;
            else if (g_b) m_prio = 1'b0;
`endif
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            w      = sb.pop_front();
            m_en   = w.en;
            m_add  = w.rd;
            m_data = w.data;
        end else begin
            m_en = 1'b0;
        end
        check("wr_en", {31'd0, rf_write_enable}, {31'd0, m_en});
        check("wr_add", {27'd0, rf_write_add}, {27'd0, m_add});
        check("wr_data", rf_write_data, m_data);
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; rsv_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [4:0] exp_grants[4];
        rst = 1'b0;
        idle_inputs();
        a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
        rsv_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", {31'd0, rf_write_enable}, 32'd0);
        check("rst_add", {27'd0, rf_write_add}, 32'd0);
        check("rst_data", rf_write_data, 32'd0);
        chk_rs1 = 5; chk_rs2 = 31;
        check("rst_busy1", {31'd0, busy_rs1}, 32'd0);
        check("rst_busy2", {31'd0, busy_rs2}, 32'd0);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        rst = 1'b1;

        // A alone
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        step();
        check("a_alone_en", {31'd0, rf_write_enable}, 32'd1);
        check("a_alone_data", rf_write_data, 32'hDEADBEEF);
        idle_inputs();
        step();
        check("a_alone_en_off", {31'd0, rf_write_enable}, 32'd0);

        // Contention from priority A
        do_reset();
        a_valid = 1; b_valid = 1; a_rd = 1; b_rd = 9;
        a_data = 32'hA000_0001; b_data = 32'hB000_0009;
        for (int i = 0; i < 4; i++) begin
            step();
            grants.push_back(rf_write_add);
            if (g_a) begin a_rd = a_rd + 5'd1; a_data = a_data + 1; end
            if (g_b) begin b_rd = b_rd + 5'd1; b_data = b_data + 1; end
        end
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_grants = '{5'd1, 5'd9, 5'd2, 5'd10};
`else
        exp_grants = '{5'd1, 5'd2, 5'd3, 5'd4};
`endif
        for (int i = 0; i < 4; i++) check("grant_order", {27'd0, grants[i]}, {27'd0, exp_grants[i]});
        idle_inputs();
        repeat (2) step();

        // Scoreboard: reserve r7, B writes it two cycles later
        rsv_valid = 1; rsv_rd = 7; chk_rs1 = 7; chk_rs2 = 0;
        step();
        check("sb_busy_set", {31'd0, busy_rs1}, 32'd1);
        rsv_valid = 0;
        step();
        b_valid = 1; b_rd = 7; b_data = 32'h0000_0777;
        step();
        b_valid = 0;
        check("sb_busy_during_wr", {31'd0, busy_rs1}, 32'd1);
        step();
        check("sb_busy_cleared", {31'd0, busy_rs1}, 32'd0);

        // Set/clear collision on r3
        a_valid = 1; a_rd = 3; a_data = 32'h3333_3333; chk_rs1 = 3;
        step();
        a_valid = 0; rsv_valid = 1; rsv_rd = 3;
        step();
        rsv_valid = 0;
        step();
        check("collision_busy", {31'd0, busy_rs1}, 32'd1);

        // x0 write and reservation
        a_valid = 1; a_rd = 0; a_data = 32'h1234; rsv_valid = 1; rsv_rd = 0; chk_rs1 = 0;
        step();
        idle_inputs();
        check("x0_en", {31'd0, rf_write_enable}, 32'd0);
        step();
        check("x0_busy", {31'd0, busy_rs1}, 32'd0);

        // Reset mid-operation
        rsv_valid = 1; rsv_rd = 8; chk_rs1 = 8; chk_rs2 = 9;
        step();
        rsv_rd = 9;
        step();
        rsv_valid = 0; a_valid = 1; a_rd = 8; a_data = 32'h8888_0008;
        step();
        check("mid_busy_before", {31'd0, busy_rs2}, 32'd1);
        do_reset();
        check("mid_rst_en", {31'd0, rf_write_enable}, 32'd0);
        check("mid_rst_busy1", {31'd0, busy_rs1}, 32'd0);
        check("mid_rst_busy2", {31'd0, busy_rs2}, 32'd0);
        a_valid = 1; b_valid = 1; a_rd = 12; b_rd = 13;
        step();
        check("mid_first_grant", {27'd0, rf_write_add}, 32'd12);
        idle_inputs();
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
